// File: rtl/lock_key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lock_key_pkg
// Description : Shared widths, FSM state encoding, CRC-8 constants and
//               key-field slice helpers for the lock key loader.
//               Key layout: [MUX_KEY_W-1:0] = p1..p4,
//                           [KEY_W-1:MUX_KEY_W] = X_1..X_34.
// Revision    : 1.0 - initial release
// ============================================================================
package lock_key_pkg;

    localparam int MUX_KEY_W = 4;
    localparam int XOR_KEY_W = 34;
    localparam int KEY_W     = MUX_KEY_W + XOR_KEY_W;

    // Bit counter must be able to hold KEY_W itself (saturating end value).
    localparam int CNT_W     = $clog2(KEY_W + 1);

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // p1..p4 mux-key field.
    function automatic logic [MUX_KEY_W-1:0] mux_field(input logic [KEY_W-1:0] key);
        return key[MUX_KEY_W-1:0];
    endfunction

    // X_1..X_34 XOR-key field.
    function automatic logic [XOR_KEY_W-1:0] xor_field(input logic [KEY_W-1:0] key);
        return key[KEY_W-1:MUX_KEY_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lock_key_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : lock_key_loader_if
// Description : Control, serial-key handshake and parallel key output bundle
//               between the key store (master) and the loader (slave).
//   load_start/load_abort         : load control from the key store
//   key_bit_in/valid/ready        : serial bit handshake
//   key_out/key_valid/key_err/busy: parallel key word and status
// Revision    : 1.0 - initial release
// ============================================================================
interface lock_key_loader_if;
    import lock_key_pkg::*;

    logic             load_start;
    logic             load_abort;
    logic             key_bit_in;
    logic             key_bit_valid;
    logic             key_bit_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             key_err;
    logic             busy;

    modport master (
        output load_start,
        output load_abort,
        output key_bit_in,
        output key_bit_valid,
        input  key_bit_ready,
        input  key_out,
        input  key_valid,
        input  key_err,
        input  busy
    );

    modport slave (
        input  load_start,
        input  load_abort,
        input  key_bit_in,
        input  key_bit_valid,
        output key_bit_ready,
        output key_out,
        output key_valid,
        output key_err,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/crc8_serial.sv
`default_nettype none
// ============================================================================
// Module      : crc8_serial
// Description : Bit-serial CRC-8 (MSB-first LFSR, polynomial CRC8_POLY,
//               seed CRC8_INIT), one message bit per enabled cycle.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : reload seed (takes priority over i_en)
//   i_en     : absorb i_bit this cycle
//   i_bit    : message bit
//   o_crc    : running remainder
// Revision    : 1.0 - initial release
// ============================================================================
module crc8_serial
    import lock_key_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [7:0] o_crc
);

    logic [7:0] r_crc;
    logic       w_fb;

    assign w_fb = r_crc[7] ^ i_bit;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_crc <= CRC8_INIT;
        end else if (i_en) begin
            r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? CRC8_POLY : 8'h00);
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/lock_key_loader.sv
`default_nettype none
// ============================================================================
// Module      : lock_key_loader
// Description : Assembles the 38-bit c432 unlock key from a serial
//               valid/ready stream and presents it as one parallel word,
//               held at zero until a complete (and, optionally, CRC-checked)
//               key has been received.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lock_key_loader_if.slave (control, serial bits, key/status)
// Build option: define LOCK_KEY_CRC_EN to require an 8-bit CRC-8 trailer
//               (MSB first) after the key bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_key_loader
    import lock_key_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
)
(
    input  logic                     clk,
    input  logic                     rst,
    lock_key_loader_if.slave         bus
);

    localparam int c_idle_w = $clog2(TIMEOUT_CYC + 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [KEY_W-1:0]    r_shadow;
    logic [KEY_W-1:0]    w_shadow_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [c_idle_w-1:0] r_idle_cnt;
    logic [KEY_W-1:0]    r_key_out;

    logic w_ready;
    logic w_start;
    logic w_abort;
    logic w_xfer;
    logic w_shift;
    logic w_last_key;
    logic w_timeout;

    assign w_ready = (r_state == ST_SHIFT) || (r_state == ST_CHECK);
    assign w_start = bus.load_start &&
                     ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_abort = bus.load_abort && w_ready;
    // Abort wins over a coincident bit: that bit is simply dropped.
    assign w_xfer  = bus.key_bit_valid && w_ready && !w_abort;
    assign w_shift = w_xfer && (r_state == ST_SHIFT);
    assign w_last_key = w_shift && (r_bit_cnt == CNT_W'(KEY_W - 1));
    assign w_timeout  = w_ready && !w_xfer && !w_abort &&
                        (r_idle_cnt == c_idle_w'(TIMEOUT_CYC - 1));

    // Shadow including the bit being accepted now, so the final key bit is
    // visible in key_out on the same edge that enters DONE.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_shift && (r_bit_cnt < CNT_W'(KEY_W))) begin
            w_shadow_nxt[r_bit_cnt] = bus.key_bit_in;
        end
    end

`ifdef LOCK_KEY_CRC_EN
    logic [7:0] w_crc;
    logic [2:0] r_trl_cnt;
    logic [6:0] r_trl;
    logic       w_trl_last;
    logic       w_crc_ok;

    crc8_serial u_crc8 (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_start),
        .i_en  (w_shift),
        .i_bit (bus.key_bit_in),
        .o_crc (w_crc)
    );

    assign w_trl_last = w_xfer && (r_state == ST_CHECK) && (r_trl_cnt == 3'd7);
    // Trailer arrives MSB first: the first seven bits sit in r_trl, the
    // eighth is the live input.
    assign w_crc_ok   = ({r_trl, bus.key_bit_in} == w_crc);

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_trl_cnt <= 3'd0;
            r_trl     <= 7'd0;
        end else if (w_xfer && (r_state == ST_CHECK)) begin
            r_trl_cnt <= r_trl_cnt + 3'd1;
            r_trl     <= {r_trl[5:0], bus.key_bit_in};
        end
    end
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.load_start) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_last_key) begin
`ifdef LOCK_KEY_CRC_EN
                    w_next_state = ST_CHECK;
`else
                    w_next_state = ST_DONE;
`endif
                end else if (w_timeout) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_CHECK: begin
`ifdef LOCK_KEY_CRC_EN
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_trl_last) begin
                    w_next_state = w_crc_ok ? ST_DONE : ST_ERR;
                end else if (w_timeout) begin
                    w_next_state = ST_ERR;
                end
`else
                w_next_state = ST_IDLE;
`endif
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow   <= '0;
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
            r_key_out  <= '0;
        end else if (w_start) begin
            r_shadow   <= '0;
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
            r_key_out  <= '0;
        end else begin
            r_shadow <= w_shadow_nxt;
            if (w_shift && (r_bit_cnt != CNT_W'(KEY_W))) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_xfer) begin
                r_idle_cnt <= '0;
            end else if (w_ready && (r_idle_cnt != c_idle_w'(TIMEOUT_CYC))) begin
                r_idle_cnt <= r_idle_cnt + c_idle_w'(1);
            end
            // key_out only ever changes from zero on entry to DONE; every
            // other path (load, abort, error) leaves it at zero.
            if ((w_next_state == ST_DONE) && (r_state != ST_DONE)) begin
                r_key_out <= w_shadow_nxt;
            end
        end
    end

    assign bus.key_bit_ready = w_ready;
    assign bus.busy          = w_ready;
    assign bus.key_valid     = (r_state == ST_DONE);
    assign bus.key_err       = (r_state == ST_ERR);
    assign bus.key_out       = r_key_out;

endmodule
`default_nettype wire

// File: tb/tb_lock_key_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_key_loader
// Description : Self-checking bench for lock_key_loader. Keys are sent
//               LSB first; the expected CRC-8 trailer is derived by
//               polynomial long division of the key (arrival order) times
//               x^8 by x^8+x^2+x+1. Honours LOCK_KEY_CRC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_key_loader;
    import lock_key_pkg::*;

    localparam int TO = 1024;
`ifdef LOCK_KEY_CRC_EN
    localparam bit c_crc_en = 1'b1;
`else
    localparam bit c_crc_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    lock_key_loader_if bus ();

    lock_key_loader #(.TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc_model(input logic [KEY_W-1:0] key);
        logic [KEY_W+7:0] p;
        p = '0;
        for (int n = 0; n < KEY_W; n++) p[KEY_W+7-n] = key[n];
        for (int d = KEY_W + 7; d >= 8; d--)
            if (p[d]) p[d -: 9] = p[d -: 9] ^ 9'h107;
        return p[7:0];
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_key_out"}, 64'(bus.key_out), 64'd0);
        check({tag, "_valid"},   64'(bus.key_valid), 64'd0);
        check({tag, "_err"},     64'(bus.key_err), 64'd0);
        check({tag, "_busy"},    64'(bus.busy), 64'd0);
        check({tag, "_ready"},   64'(bus.key_bit_ready), 64'd0);
    endtask

    // All tasks enter and leave on a negedge.
    task automatic start_load();
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        int budget = 50;
        repeat (gap) @(negedge clk);
        while (!bus.key_bit_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!bus.key_bit_ready) check("ready_wait", 64'd0, 64'd1);
        bus.key_bit_in    = b;
        bus.key_bit_valid = 1'b1;
        @(negedge clk);
        bus.key_bit_valid = 1'b0;
        bus.key_bit_in    = 1'($urandom);
    endtask

    task automatic do_load(input string tag, input logic [KEY_W-1:0] key,
                           input logic [7:0] flip, input int gmin, input int gmax);
        logic [7:0] trl;
        logic       ok;
        trl = crc_model(key) ^ flip;
        ok  = c_crc_en ? (flip == 8'h00) : 1'b1;
        start_load();
        for (int n = 0; n < KEY_W; n++) begin
            send_bit(key[n], $urandom_range(gmax, gmin));
            if (n == 19) begin
                check({tag, "_mid_out"},  64'(bus.key_out), 64'd0);
                check({tag, "_mid_busy"}, 64'(bus.busy), 64'd1);
            end
        end
`ifdef LOCK_KEY_CRC_EN
        for (int i = 7; i >= 0; i--) send_bit(trl[i], $urandom_range(gmax, gmin));
`endif
        check({tag, "_valid"}, 64'(bus.key_valid), ok ? 64'd1 : 64'd0);
        check({tag, "_err"},   64'(bus.key_err),   ok ? 64'd0 : 64'd1);
        check({tag, "_out"},   64'(bus.key_out),   ok ? 64'(key) : 64'd0);
        check({tag, "_busy"},  64'(bus.busy),      64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [KEY_W-1:0] k;
        logic [7:0]       f;
        bus.load_start    = 1'b0;
        bus.load_abort    = 1'b0;
        bus.key_bit_in    = 1'b0;
        bus.key_bit_valid = 1'b0;

        // Reset then idle.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_state("rst");

        // Basic load.
        k = 38'h2A_5555_AAAA;
        do_load("basic", k, 8'h00, 0, 1);
        check("basic_mux", 64'(mux_field(bus.key_out)), 64'hA);
        check("basic_xor", 64'(xor_field(bus.key_out)), 64'(k[KEY_W-1:MUX_KEY_W]));

        // All-zero key (trailer 0x00 when CRC is present).
        check("zero_crc_model", 64'(crc_model('0)), 64'h00);
        do_load("zero", '0, 8'h00, 0, 0);

`ifdef LOCK_KEY_CRC_EN
        // Trailer bit 0 flipped.
        do_load("crc_bad", 38'h2A_5555_AAAA, 8'h01, 0, 1);
`endif

        // Backpressure gaps of 5 cycles.
        k = {$urandom, $urandom};
        do_load("gap5", k, 8'h00, 5, 5);

        // Timeout after bit 20.
        k = {$urandom, $urandom};
        start_load();
        for (int n = 0; n <= 20; n++) send_bit(k[n], 0);
        repeat (TO - 5) @(negedge clk);
        check("to_early_err",  64'(bus.key_err), 64'd0);
        check("to_early_busy", 64'(bus.busy), 64'd1);
        repeat (10) @(negedge clk);
        check("to_err",   64'(bus.key_err), 64'd1);
        check("to_busy",  64'(bus.busy), 64'd0);
        check("to_valid", 64'(bus.key_valid), 64'd0);
        check("to_ready", 64'(bus.key_bit_ready), 64'd0);
        check("to_out",   64'(bus.key_out), 64'd0);

        // Abort at bit 30 together with a valid bit.
        k = {$urandom, $urandom};
        start_load();
        for (int n = 0; n < 30; n++) send_bit(k[n], 0);
        bus.load_abort    = 1'b1;
        bus.key_bit_valid = 1'b1;
        bus.key_bit_in    = k[30];
        @(negedge clk);
        bus.load_abort    = 1'b0;
        bus.key_bit_valid = 1'b0;
        check_reset_state("abort");

        // Recovery after abort, then reload from DONE.
        k = {$urandom, $urandom};
        do_load("post_abort", k, 8'h00, 0, 2);
        start_load();
        check("reload_valid", 64'(bus.key_valid), 64'd0);
        check("reload_out",   64'(bus.key_out), 64'd0);
        check("reload_busy",  64'(bus.busy), 64'd1);
        bus.load_abort = 1'b1;
        @(negedge clk);
        bus.load_abort = 1'b0;

        // Reset at bit 17.
        k = {$urandom, $urandom};
        start_load();
        for (int n = 0; n < 17; n++) send_bit(k[n], 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrst");
        k = {$urandom, $urandom};
        do_load("post_rst", k, 8'h00, 0, 2);

        // Randomized loads, some with a corrupted trailer.
        for (int t = 0; t < 6; t++) begin
            k = {$urandom, $urandom};
            f = ($urandom_range(2, 0) == 0) ? (8'h01 << $urandom_range(7, 0)) : 8'h00;
            do_load($sformatf("rand%0d", t), k, f, 0, 3);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
